// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch front end.
// Holds the sequencer state encoding and the word-width defaults.
package fetch_pkg;

  localparam int DEF_XLEN = 32;
  localparam logic [DEF_XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int DEF_PC_STEP = 4;

  typedef logic [DEF_XLEN-1:0] word_t;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register for the fetch sequencer.
// A load writes a word-aligned target; a load wins over an increment.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
  parameter int PC_STEP = DEF_PC_STEP
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [XLEN-1:0] target,
  input  logic            inc,
  output logic [XLEN-1:0] pc
);

  // PC update: redirect target (low bits cleared) or sequential step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= {target[XLEN-1:2], 2'b00};
    end else if (inc) begin
      pc <= pc + XLEN'(PC_STEP);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Front-end fetch control: PC, one-at-a-time imem requests,
// decode handshake and redirect/squash of in-flight fetches.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
  parameter int PC_STEP = DEF_PC_STEP
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] pc
);

  fetch_state_t state;
  logic         flush_pending;
  logic         pc_inc;

  // A redirect always retargets the PC, whatever the state
  assign pc_inc = (state == HOLD) && !redirect && !stall;

  fetch_pc_reg #(
    .XLEN    (XLEN),
    .RESET_PC(RESET_PC),
    .PC_STEP (PC_STEP)
  ) u_pc (
    .clk   (clk),
    .reset (reset),
    .load  (redirect),
    .target(redirect_pc),
    .inc   (pc_inc),
    .pc    (pc)
  );

  assign imem_req  = !reset && (state == FETCH) && !redirect;
  assign imem_addr = pc;

  // Fetch FSM with registered decode outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= FETCH;
      flush_pending <= 1'b0;
      instr_valid   <= 1'b0;
      instr         <= '0;
      instr_pc      <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (!redirect) state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            flush_pending <= 1'b0;
            if (redirect || flush_pending) begin
              state <= FETCH;
            end else begin
              instr       <= imem_rdata;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              state       <= HOLD;
            end
          end else if (redirect) begin
            flush_pending <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect || !stall) begin
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: cycle table plus redirect/reset
// sequences, with a request/instruction scoreboard.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  logic  imem_req;
  word_t imem_addr;
  logic  imem_rvalid = 1'b0;
  word_t imem_rdata = '0;
  logic  redirect = 1'b0;
  word_t redirect_pc = '0;
  logic  stall = 1'b0;
  logic  instr_valid;
  word_t instr;
  word_t instr_pc;
  word_t pc;

  int total = 0;
  int bad = 0;
  int lat = 1;

  word_t exp_addr[$];
  word_t exp_pc[$];

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .stall      (stall),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .pc         (pc)
  );

  task automatic chk(input string name, input word_t act, input word_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 40; i++) begin
      if (imem_req) return;
      cyc();
    end
    total++;
    bad++;
    $display("FAIL wait_req: got no request expected one within 40 cycles");
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 40; i++) begin
      if (instr_valid) return;
      cyc();
    end
    total++;
    bad++;
    $display("FAIL wait_valid: got no instr_valid expected one within 40 cycles");
  endtask

  // Memory model: answers each request after lat cycles with ~addr
  logic  busy = 1'b0;
  int    cnt = 0;
  word_t maddr = '0;
  always @(negedge clk) begin
    imem_rvalid <= 1'b0;
    imem_rdata  <= $urandom;
    if (busy && cnt == 1) begin
      imem_rvalid <= 1'b1;
      imem_rdata  <= ~maddr;
    end
    if (imem_req) begin
      busy  <= 1'b1;
      cnt   <= lat;
      maddr <= imem_addr;
    end else if (busy) begin
      cnt <= cnt - 1;
      if (cnt == 1) busy <= 1'b0;
    end
  end

  // Scoreboard: every request and every new instruction is expected
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (imem_req) begin
      if (exp_addr.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_req: got request %h expected none", imem_addr);
      end else begin
        chk("sb_addr", imem_addr, exp_addr.pop_front());
      end
    end
    if (instr_valid && !prev_valid) begin
      if (exp_pc.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_instr: got instr_pc %h expected none", instr_pc);
      end else begin
        word_t e;
        e = exp_pc.pop_front();
        chk("sb_pc", instr_pc, e);
        chk("sb_instr", instr, ~e);
      end
    end
    prev_valid <= instr_valid;
  end

  typedef struct {
    logic  stall;
    logic  req;
    word_t addr;
    logic  valid;
    word_t ipc;
  } vec_t;

  vec_t tv[14];

  initial begin
    tv[0]  = '{1'b0, 1'b1, 32'h0, 1'b0, 32'h0};
    tv[1]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
    tv[2]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0};
    tv[3]  = '{1'b0, 1'b1, 32'h4, 1'b0, 32'h0};
    tv[4]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
    tv[5]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h4};
    tv[6]  = '{1'b0, 1'b1, 32'h8, 1'b0, 32'h0};
    tv[7]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
    tv[8]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h8};
    tv[9]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h8};
    tv[10] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h8};
    tv[11] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h8};
    tv[12] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h8};
    tv[13] = '{1'b0, 1'b1, 32'hC, 1'b0, 32'h0};

    // Reset state
    repeat (3) cyc();
    chk("rst_req", word_t'(imem_req), 0);
    chk("rst_valid", word_t'(instr_valid), 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ipc", instr_pc, 32'h0);

    // Sequential fetch with 1-cycle memory and a 4-cycle stall
    exp_addr = '{32'h0, 32'h4, 32'h8, 32'hC};
    exp_pc   = '{32'h0, 32'h4, 32'h8};
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      stall = tv[i].stall;
      #1;
      chk($sformatf("tv%0d_req", i), word_t'(imem_req), word_t'(tv[i].req));
      if (tv[i].req) chk($sformatf("tv%0d_addr", i), imem_addr, tv[i].addr);
      chk($sformatf("tv%0d_valid", i), word_t'(instr_valid), word_t'(tv[i].valid));
      if (tv[i].valid) begin
        chk($sformatf("tv%0d_ipc", i), instr_pc, tv[i].ipc);
        chk($sformatf("tv%0d_instr", i), instr, ~tv[i].ipc);
      end
      cyc();
    end

    // Redirect while waiting on a 3-cycle memory: response dropped
    lat = 3;
    exp_pc.push_back(32'hC);
    exp_addr.push_back(32'h10);
    wait_req();
    chk("r1_addr", imem_addr, 32'h10);
    cyc();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    cyc();
    redirect = 1'b0;
    #1;
    chk("r1_pc", pc, 32'h100);
    chk("r1_valid_a", word_t'(instr_valid), 0);
    exp_addr.push_back(32'h100);
    cyc();
    chk("r1_valid_b", word_t'(instr_valid), 0);
    chk("r1_noreq", word_t'(imem_req), 0);
    cyc();
    chk("r1_req", word_t'(imem_req), 1);
    chk("r1_addr2", imem_addr, 32'h100);
    chk("r1_valid_c", word_t'(instr_valid), 0);
    lat = 1;
    exp_pc.push_back(32'h100);
    exp_addr.push_back(32'h104);

    // Redirect to a misaligned target in the rvalid cycle
    cyc();
    wait_req();
    chk("r2_addr", imem_addr, 32'h104);
    cyc();
    redirect = 1'b1;
    redirect_pc = 32'h203;
    exp_addr.push_back(32'h200);
    cyc();
    redirect = 1'b0;
    #1;
    chk("r2_req", word_t'(imem_req), 1);
    chk("r2_addr2", imem_addr, 32'h200);
    chk("r2_valid", word_t'(instr_valid), 0);
    exp_pc.push_back(32'h200);

    // Redirect beats stall in HOLD
    stall = 1'b1;
    cyc();
    cyc();
    chk("r3_valid", word_t'(instr_valid), 1);
    chk("r3_ipc", instr_pc, 32'h200);
    redirect = 1'b1;
    redirect_pc = 32'h40;
    exp_addr.push_back(32'h40);
    cyc();
    redirect = 1'b0;
    stall = 1'b0;
    #1;
    chk("r3_drop", word_t'(instr_valid), 0);
    chk("r3_req", word_t'(imem_req), 1);
    chk("r3_addr", imem_addr, 32'h40);
    exp_pc.push_back(32'h40);

    // PC wrap from the top of the address space
    wait_valid();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    exp_addr.push_back(32'hFFFF_FFFC);
    cyc();
    redirect = 1'b0;
    #1;
    chk("w_addr", imem_addr, 32'hFFFF_FFFC);
    exp_pc.push_back(32'hFFFF_FFFC);
    exp_addr.push_back(32'h0);
    cyc();
    wait_valid();
    cyc();
    chk("w_req", word_t'(imem_req), 1);
    chk("w_pc", pc, 32'h0);
    exp_pc.push_back(32'h0);
    exp_addr.push_back(32'h4);

    // Async reset in WAIT; late response lands in FETCH
    cyc();
    lat = 3;
    cyc();
    wait_req();
    chk("rs_addr", imem_addr, 32'h4);
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    chk("rs_pc", pc, 32'h0);
    chk("rs_req", word_t'(imem_req), 0);
    chk("rs_valid", word_t'(instr_valid), 0);
    exp_addr.push_back(32'h0);
    cyc();
    reset = 1'b0;
    stall = 1'b1;
    #1;
    chk("rs_req2", word_t'(imem_req), 1);
    chk("rs_addr2", imem_addr, 32'h0);
    exp_pc.push_back(32'h0);
    cyc();
    wait_valid();
    chk("rs_ipc", instr_pc, 32'h0);
    repeat (3) cyc();
    chk("rs_hold", word_t'(instr_valid), 1);
    chk("rs_noreq", word_t'(imem_req), 0);

    chk("sb_left_addr", word_t'(exp_addr.size()), 0);
    chk("sb_left_pc", word_t'(exp_pc.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controls the program counter and the instruction-memory fetch handshake for the CPU front end. It owns the PC register and issues one instruction-memory request at a time. It presents each fetched instruction to decode with a valid/stall handshake. Branch and JALR redirects from execute are applied here, including squashing a fetch already in flight.

Parameters:
XLEN, 32, PC / address / instruction width
RESET_PC, 32'h0000_0000, PC value loaded by reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  one-cycle request pulse to instruction memory
imem_addr  out  XLEN  fetch address, valid while imem_req=1
imem_rvalid  in  1  memory response valid, one cycle per request
imem_rdata  in  XLEN  instruction word, valid with imem_rvalid
redirect  in  1  branch taken / JALR from execute
redirect_pc  in  XLEN  redirect target
stall  in  1  decode cannot accept an instruction this cycle
instr_valid  out  1  instr and instr_pc are valid for decode
instr  out  XLEN  fetched instruction word
instr_pc  out  XLEN  address of instr
pc  out  XLEN  current fetch PC

Behaviour:
- Reset (async, active-high): state=FETCH, pc=RESET_PC, instr_valid=0, instr=0, instr_pc=0, flush_pending=0. imem_req is 0 while reset=1.
- FSM states: FETCH, WAIT, HOLD. All state and output registers update on posedge clk.
- FETCH:
  - imem_req = !redirect, with imem_addr=pc.
  - redirect=1: no request is issued; pc<=redirect_pc; stay in FETCH.
  - Otherwise go to WAIT.
- WAIT:
  - rvalid=1 and redirect=0 and flush_pending=0: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, go to HOLD.
  - rvalid=1 and flush_pending=1: discard the data, clear flush_pending, go to FETCH. pc already holds the redirect target.
  - redirect=1 and rvalid=0: pc<=redirect_pc, flush_pending<=1, stay in WAIT.
  - redirect=1 and rvalid=1 in the same cycle: discard the data, pc<=redirect_pc, flush_pending<=0, go to FETCH.
  - Repeated redirects while waiting: the last redirect_pc wins.
  - No timeout. The block waits indefinitely.
- HOLD (instr_valid=1):
  - redirect=1: instr_valid<=0, pc<=redirect_pc, go to FETCH. Redirect has priority over stall.
  - stall=0: the instruction is consumed this cycle. instr_valid<=0, pc<=pc+PC_STEP, go to FETCH.
  - stall=1: hold instr, instr_pc and instr_valid unchanged.
- imem_rvalid outside WAIT is ignored and causes no state change.
- Width rules:
  - pc+PC_STEP is modulo 2^XLEN, so 32'hFFFF_FFFC wraps to 0.
  - redirect_pc[1:0] is forced to 2'b00 when loaded.
- Latency:
  - First request is issued in the first cycle after reset deasserts.
  - With a 1-cycle memory and no stall: FETCH(n), WAIT(n+1, rvalid), HOLD(n+2), FETCH(n+3). One instruction every 3 cycles.
- Exactly one outstanding request at any time. imem_req is never asserted in WAIT or HOLD.
- Reset mid-operation: an immediate return to the reset values. Any in-flight response that arrives after reset is ignored, because it lands in FETCH.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum fetch_state_t {FETCH, WAIT, HOLD}
  - XLEN, RESET_PC and PC_STEP defaults
  - a typedef for the XLEN-wide word
- One sub-module, fetch_pc_reg. It contains the PC register with async reset to RESET_PC, a load port (target, low bits cleared) and an increment enable. Load has priority over increment.
- The FSM and instruction/valid registers stay in fetch_sequencer.

Test Plan:
- Reset, then a 1-cycle-latency memory, stall=0 -> imem_addr sequence 0x0, 0x4, 0x8. instr_valid pulses once every 3 cycles with instr_pc 0x0, 0x4, 0x8.
- In HOLD with instr_pc=0x8, stall=1 for 4 cycles, then 0 -> instr/instr_pc stable for 4 cycles. Next imem_addr=0xC. No extra imem_req during the stall.
- Redirect to 0x100 while in WAIT for 0x10 with 3-cycle memory latency -> the 0x10 response is dropped (instr_valid stays 0). Next imem_addr=0x100.
- Redirect to 0x203 in the same cycle as imem_rvalid in WAIT -> data discarded, next imem_addr=0x200.
- Redirect to 0x40 with stall=1 in HOLD -> instr_valid drops the next cycle, next imem_addr=0x40.
- pc=0xFFFF_FFFC consumed -> next imem_addr=0x0. Async reset asserted mid-WAIT -> pc=RESET_PC immediately. A late rvalid after reset is ignored, and the first post-reset request goes to RESET_PC.
